// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared fetch-path types and constants
// Purpose: XLEN, the fetch entry record carried through the instruction queue,
//          and the mask used to detect a misaligned (non word-aligned) PC.
// Ports:   none (package).
package rv32i_pkg;

    localparam int XLEN = 32;

    // Low PC bits that must be zero for a 32-bit aligned fetch.
    localparam logic [1:0] MISALIGN_MASK = 2'b11;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            err;
    } fetch_entry_t;

endpackage

// File: rtl/ifq_storage.sv
// rtl/ifq_storage.sv - DEPTH x fetch_entry_t register array
// Purpose: entry storage for instruction_queue; one synchronous write port,
//          one combinational read port, data is not reset.
// Ports:   clk   - clock
//          we    - write enable, waddr/wdata - write address and entry
//          raddr - read address, rdata - entry at raddr (combinational)
import rv32i_pkg::*;

module ifq_storage #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  fetch_entry_t             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output fetch_entry_t             rdata
);

    fetch_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/instruction_queue.sv
// rtl/instruction_queue.sv - fetch-to-decode decoupling FIFO with flush
// Purpose: buffers {pc, instr, err} from fetch and hands them to decode in
//          order over valid/ready; a redirect (flush) drops everything.
// Optional: IFQ_BYPASS_EN - when empty, the offered entry drives out_*
//           combinationally and is consumed without being stored.
// Ports:   ifq_clk, ifq_rst (async, active low), flush
//          in_valid/in_ready/in_pc/in_instr/in_pc_error - fetch side
//          out_valid/out_ready/out_pc/out_instr/out_err - decode side
//          count - current occupancy
import rv32i_pkg::*;

module instruction_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = rv32i_pkg::XLEN
) (
    input  logic                     ifq_clk,
    input  logic                     ifq_rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_instr,
    input  logic                     in_pc_error,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_instr,
    output logic                     out_err,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic         empty, full, push, pop, bypass;
    fetch_entry_t wdata, rdata, head;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // Error is resolved at push time so decode sees a single stored flag.
    assign wdata.pc    = in_pc;
    assign wdata.instr = in_instr;
    assign wdata.err   = in_pc_error | (|(in_pc[1:0] & MISALIGN_MASK));

`ifdef IFQ_BYPASS_EN
    assign bypass    = empty && in_valid && out_ready && !flush;
    assign out_valid = empty ? in_valid : 1'b1;
    assign head      = empty ? wdata : rdata;
`else
    assign bypass    = 1'b0;
    assign out_valid = !empty;
    assign head      = rdata;
`endif

    // in_ready looks only at registered occupancy, so a same-cycle pop
    // never opens a slot for a push when full.
    assign in_ready = !full;
    assign push     = in_valid && !full && !flush && !bypass;
    assign pop      = !empty && out_ready && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge ifq_clk or negedge ifq_rst) begin
        if (!ifq_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    ifq_storage #(.DEPTH(DEPTH)) u_storage (
        .clk   (ifq_clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wdata),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    // Storage is not reset; mask the head so outputs read zero when idle.
    assign out_pc    = out_valid ? head.pc    : '0;
    assign out_instr = out_valid ? head.instr : '0;
    assign out_err   = out_valid ? head.err   : 1'b0;
    assign count     = count_q;

endmodule

// File: tb/tb_instruction_queue.sv
// tb/tb_instruction_queue.sv - directed table-driven bench for instruction_queue
module tb_instruction_queue;

    logic        ifq_clk = 1'b0;
    logic        ifq_rst, flush, in_valid, in_ready, in_pc_error;
    logic        out_valid, out_ready, out_err;
    logic [31:0] in_pc, in_instr, out_pc, out_instr;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 ifq_clk = ~ifq_clk;

    instruction_queue dut (
        .ifq_clk     (ifq_clk),
        .ifq_rst     (ifq_rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_pc       (in_pc),
        .in_instr    (in_instr),
        .in_pc_error (in_pc_error),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_instr   (out_instr),
        .out_err     (out_err),
        .count       (count)
    );

    typedef struct {
        logic        fl, iv;
        logic [31:0] pc;
        logic        perr, ordy;
        logic        e_irdy, e_ov;
        logic [31:0] e_pc;
        logic        e_err;
        logic [2:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic fl, iv, input logic [31:0] pc,
                                input logic perr, ordy, e_irdy, e_ov,
                                input logic [31:0] e_pc, input logic e_err,
                                input logic [2:0] e_cnt);
        vec_t v;
        v.fl = fl; v.iv = iv; v.pc = pc; v.perr = perr; v.ordy = ordy;
        v.e_irdy = e_irdy; v.e_ov = e_ov; v.e_pc = e_pc; v.e_err = e_err;
        v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, iv, input logic [31:0] pc, input logic perr, ordy);
        flush       = fl;
        in_valid    = iv;
        in_pc       = pc;
        in_instr    = pc ^ 32'h0000_0013;
        in_pc_error = perr;
        out_ready   = ordy;
    endtask

    task automatic step();
        @(posedge ifq_clk);
        #1;
    endtask

    // Expected values describe the outputs while the vector's inputs are
    // applied, i.e. before the edge that acts on them.
    task automatic apply(input vec_t v, input int idx);
        drive(v.fl, v.iv, v.pc, v.perr, v.ordy);
        #2;
        chk($sformatf("v%0d.in_ready", idx), {31'd0, in_ready}, {31'd0, v.e_irdy});
        chk($sformatf("v%0d.out_valid", idx), {31'd0, out_valid}, {31'd0, v.e_ov});
        chk($sformatf("v%0d.out_pc", idx), out_pc, v.e_pc);
        chk($sformatf("v%0d.out_instr", idx), out_instr,
            v.e_ov ? (v.e_pc ^ 32'h0000_0013) : 32'd0);
        chk($sformatf("v%0d.out_err", idx), {31'd0, out_err}, {31'd0, v.e_err});
        chk($sformatf("v%0d.count", idx), {29'd0, count}, {29'd0, v.e_cnt});
        step();
    endtask

    initial begin
        ifq_rst = 1'b0;
        drive(0, 0, 32'd0, 0, 0);
        repeat (2) @(posedge ifq_clk);
        #1;
        chk("reset.count", {29'd0, count}, 32'd0);
        chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset.out_pc", out_pc, 32'd0);
        chk("reset.out_err", {31'd0, out_err}, 32'd0);
        ifq_rst = 1'b1;
        step();

`ifndef IFQ_BYPASS_EN
        //           fl iv pc          pe rd  irdy ov e_pc        er cnt
        vecs.push_back(mk(0, 0, 32'h0,   0, 0,  1, 0, 32'h0,   0, 0));
        vecs.push_back(mk(0, 1, 32'h0,   0, 0,  1, 0, 32'h0,   0, 0));
        vecs.push_back(mk(0, 1, 32'h4,   0, 0,  1, 1, 32'h0,   0, 1));
        vecs.push_back(mk(0, 1, 32'h8,   0, 0,  1, 1, 32'h0,   0, 2));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0,  1, 1, 32'h0,   0, 3));
        vecs.push_back(mk(0, 0, 32'h0,   0, 1,  1, 1, 32'h0,   0, 3));
        vecs.push_back(mk(0, 0, 32'h0,   0, 1,  1, 1, 32'h4,   0, 2));
        vecs.push_back(mk(0, 0, 32'h0,   0, 1,  1, 1, 32'h8,   0, 1));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0,  1, 0, 32'h0,   0, 0));
        // fill to DEPTH, then push+pop while full
        vecs.push_back(mk(0, 1, 32'h10,  0, 0,  1, 0, 32'h0,   0, 0));
        vecs.push_back(mk(0, 1, 32'h14,  0, 0,  1, 1, 32'h10,  0, 1));
        vecs.push_back(mk(0, 1, 32'h18,  0, 0,  1, 1, 32'h10,  0, 2));
        vecs.push_back(mk(0, 1, 32'h1C,  0, 0,  1, 1, 32'h10,  0, 3));
        vecs.push_back(mk(0, 1, 32'h20,  0, 1,  0, 1, 32'h10,  0, 4));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0,  1, 1, 32'h14,  0, 3));
        vecs.push_back(mk(0, 0, 32'h0,   0, 1,  1, 1, 32'h14,  0, 3));
        vecs.push_back(mk(0, 0, 32'h0,   0, 1,  1, 1, 32'h18,  0, 2));
        vecs.push_back(mk(0, 0, 32'h0,   0, 1,  1, 1, 32'h1C,  0, 1));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0,  1, 0, 32'h0,   0, 0));
        // streaming 0x100..0x124, one in flight, pointers wrap
        vecs.push_back(mk(0, 1, 32'h100, 0, 1,  1, 0, 32'h0,   0, 0));
        for (int k = 1; k < 10; k++)
            vecs.push_back(mk(0, 1, 32'h100 + 32'(4 * k), 0, 1,
                              1, 1, 32'h100 + 32'(4 * (k - 1)), 0, 1));
        vecs.push_back(mk(0, 0, 32'h0,   0, 1,  1, 1, 32'h124, 0, 1));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0,  1, 0, 32'h0,   0, 0));
        // flush with count=3 and a same-cycle push/pop
        vecs.push_back(mk(0, 1, 32'h200, 0, 0,  1, 0, 32'h0,   0, 0));
        vecs.push_back(mk(0, 1, 32'h204, 0, 0,  1, 1, 32'h200, 0, 1));
        vecs.push_back(mk(0, 1, 32'h208, 0, 0,  1, 1, 32'h200, 0, 2));
        vecs.push_back(mk(1, 1, 32'h20C, 0, 1,  1, 1, 32'h200, 0, 3));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0,  1, 0, 32'h0,   0, 0));
        vecs.push_back(mk(0, 1, 32'h300, 0, 0,  1, 0, 32'h0,   0, 0));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0,  1, 1, 32'h300, 0, 1));
        vecs.push_back(mk(0, 0, 32'h0,   0, 1,  1, 1, 32'h300, 0, 1));
        // error flag: misaligned, fetch error, clean
        vecs.push_back(mk(0, 1, 32'h6,   0, 0,  1, 0, 32'h0,   0, 0));
        vecs.push_back(mk(0, 1, 32'h8,   1, 0,  1, 1, 32'h6,   1, 1));
        vecs.push_back(mk(0, 1, 32'hC,   0, 0,  1, 1, 32'h6,   1, 2));
        vecs.push_back(mk(0, 0, 32'h0,   0, 1,  1, 1, 32'h6,   1, 3));
        vecs.push_back(mk(0, 0, 32'h0,   0, 1,  1, 1, 32'h8,   1, 2));
        vecs.push_back(mk(0, 0, 32'h0,   0, 1,  1, 1, 32'hC,   0, 1));
        vecs.push_back(mk(0, 0, 32'h0,   0, 0,  1, 0, 32'h0,   0, 0));

        foreach (vecs[i]) apply(vecs[i], i);
`else
        // same-cycle bypass on an empty queue
        drive(0, 1, 32'h20, 0, 1);
        #1;
        chk("byp.out_valid", {31'd0, out_valid}, 32'd1);
        chk("byp.out_pc", out_pc, 32'h20);
        chk("byp.out_instr", out_instr, 32'h20 ^ 32'h13);
        chk("byp.count", {29'd0, count}, 32'd0);
        step();
        drive(0, 0, 32'h0, 0, 0);
        #1;
        chk("byp.count_after", {29'd0, count}, 32'd0);
        chk("byp.out_valid_after", {31'd0, out_valid}, 32'd0);
        step();
`endif

        // asynchronous reset while holding two entries
        drive(0, 1, 32'h400, 0, 0);
        step();
        drive(0, 1, 32'h404, 0, 0);
        step();
        drive(0, 0, 32'h0, 0, 0);
        #1;
        chk("arst.count_before", {29'd0, count}, 32'd2);
        chk("arst.out_pc_before", out_pc, 32'h400);
        #2;
        ifq_rst = 1'b0;
        #1;
        chk("arst.count", {29'd0, count}, 32'd0);
        chk("arst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst.in_ready", {31'd0, in_ready}, 32'd1);
        chk("arst.out_pc", out_pc, 32'd0);
        step();
        ifq_rst = 1'b1;
        step();
        chk("arst.count_after", {29'd0, count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
